// File: rtl/hilo_divu.sv
// hilo_divu: multi-cycle unsigned divider (restoring, one bit per cycle) with
// its HI/LO register pair. DIVU puts the quotient in LO and the remainder in HI.
// MTHI/MTLO write HI/LO directly.
// Optional feature macro: DIVU_ZERO_SHORTCUT_EN. When it is defined, a DIVU with
// a zero divisor completes in one cycle and raises div_zero.
module hilo_divu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [5:0]  Signal,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut
);

  localparam logic [5:0] FN_DIVU = 6'b011011;
  localparam logic [5:0] FN_MTHI = 6'b010001;
  localparam logic [5:0] FN_MTLO = 6'b010011;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_n;
  logic [31:0] q, q_n;
  logic [31:0] rem, rem_n;
  logic [31:0] dvs, dvs_n;
  logic [31:0] hi, hi_n;
  logic [31:0] lo, lo_n;
  logic [4:0]  count, count_n;
  logic        done_r, done_n;
  logic        dz_r, dz_n;
  logic        zero_shortcut;

  logic [32:0] trial;
  logic [31:0] diff;
  logic        fits;
  logic [31:0] step_rem;
  logic [31:0] step_q;

`ifdef DIVU_ZERO_SHORTCUT_EN
  assign zero_shortcut = (dataB == '0);
`else
  assign zero_shortcut = 1'b0;
`endif

  // One restoring-division step. The remainder is always below the divisor,
  // so the difference fits in 32 bits whenever the trial value fits.
  always_comb begin
    trial    = {rem, q[31]};
    fits     = (trial >= {1'b0, dvs});
    diff     = trial[31:0] - dvs;
    step_rem = fits ? diff : trial[31:0];
    step_q   = {q[30:0], fits};
  end

  // Next-state and datapath control.
  always_comb begin
    state_n = state;
    q_n     = q;
    rem_n   = rem;
    dvs_n   = dvs;
    hi_n    = hi;
    lo_n    = lo;
    count_n = count;
    done_n  = 1'b0;
    dz_n    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          case (Signal)
            FN_DIVU: begin
              if (zero_shortcut) begin
                hi_n   = dataA;
                lo_n   = '1;
                done_n = 1'b1;
                dz_n   = 1'b1;
              end else begin
                q_n     = dataA;
                dvs_n   = dataB;
                rem_n   = '0;
                count_n = 5'd31;
                state_n = BUSY;
              end
            end
            FN_MTHI: hi_n = dataA;
            FN_MTLO: lo_n = dataA;
            default: ;
          endcase
        end
      end
      BUSY: begin
        rem_n   = step_rem;
        q_n     = step_q;
        count_n = count - 5'd1;
        if (count == 5'd0) begin
          hi_n    = step_rem;
          lo_n    = step_q;
          done_n  = 1'b1;
          count_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      q      <= '0;
      rem    <= '0;
      dvs    <= '0;
      hi     <= '0;
      lo     <= '0;
      count  <= '0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      state  <= state_n;
      q      <= q_n;
      rem    <= rem_n;
      dvs    <= dvs_n;
      hi     <= hi_n;
      lo     <= lo_n;
      count  <= count_n;
      done_r <= done_n;
      dz_r   <= dz_n;
    end
  end

  assign busy     = (state == BUSY);
  assign done     = done_r;
  assign div_zero = dz_r;
  assign HiOut    = hi;
  assign LoOut    = lo;

endmodule
